uart_xcvr: RTL and testbench
============================

# uart_xcvr

Parametrised full-duplex UART transceiver. It replaces the fixed-format UART with compile-time data width, parity mode, stop-bit count and oversampling ratio. Both directions use a valid/ready handshake. The receiver uses 16x (configurable) oversampling with majority-vote sampling and reports parity, framing and overrun errors. It sits between the on-chip byte-stream logic (command parsers, debug bridges) and the board RS-232 pins.

## Interface
- CLK_FREQ, 50000000, clk frequency in Hz
- BAUD, 115200, line rate in bit/s
- DATA_BITS, 8, data bits per frame; legal range 5..8
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame; 1 or 2
- OVERSAMPLE, 16, RX samples per bit; even, >= 8
- Derived DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE). DIV must be >= 2; an illegal value is an elaboration error.
- Derived BIT_CLKS = DIV*OVERSAMPLE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  8  byte to send; bits above DATA_BITS-1 are ignored
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter idle; a byte is accepted when tx_valid & tx_ready
- tx  out  1  serial output, idles high
- rx  in  1  serial input, asynchronous to clk
- rx_data  out  8  received byte, LSB-aligned; unused upper bits are 0
- rx_valid  out  1  rx_data and error flags are valid
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- rx_parity_err  out  1  parity mismatch on the frame in rx_data
- rx_frame_err  out  1  first stop bit sampled 0 on the frame in rx_data
- rx_overrun  out  1  at least one frame dropped while rx_valid was held

## Operation
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Odd parity: the parity bit is set so that data plus parity has an odd number of ones. Even parity: an even number of ones.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1, tx=1.
  - On handshake, tx_data is latched, the state goes to START, tx_ready drops, and the TX divider clears.
  - Each state bit lasts exactly BIT_CLKS clocks.
  - PARITY is skipped when PARITY=0.
  - STOP lasts STOP_BITS*BIT_CLKS clocks, then the FSM returns to IDLE.
- RX front end: a two-flop synchronizer on rx (reset to 1) produces rx_s. A free-running divider emits a one-clock tick every DIV clocks.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s=0, go to START and clear the tick count.
  - START: sample rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, then take a 2-of-3 majority. Majority 1 is a false start: return to IDLE with no output.
  - Each later bit centre falls OVERSAMPLE ticks after the previous one and uses the same 3-sample majority.
  - DATA shifts bits in LSB first. PARITY compares the sampled bit against the expected value.
  - STOP checks only the first stop bit. After its centre sample, the FSM returns to IDLE immediately, so the next start bit can be detected during the remainder of the stop time.
- Delivery at the stop-bit centre:
  - If rx_valid=0, load rx_data, rx_parity_err and rx_frame_err, and set rx_valid.
  - If rx_valid=1 and the frame is not being accepted in that cycle, drop the new frame and set rx_overrun.
- rx_valid & rx_ready clears rx_valid and rx_overrun in the next cycle. rx_data and the error flags keep their value until the next load.
- rx_parity_err is always 0 when PARITY=0.

## Timing
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0. All FSMs go to IDLE.
- Reset asserted mid-frame forces tx high asynchronously and abandons any partial RX frame. No output is produced for that frame.
- TX latency: tx falls on the clock edge that accepts the handshake, i.e. it is low from the next cycle.
- TX frame length: (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) * BIT_CLKS clocks.
- TX back-to-back: tx_ready rises on the edge that ends the last stop bit. With tx_valid held high, the next start bit begins 1 clock later, giving exactly one idle-high clock between frames.
- RX latency: rx_valid rises 1 clock after the stop-bit centre tick.
- RX start detection adds 2 clocks of synchronizer delay plus up to DIV clocks of tick phase.
- Accept and new delivery in the same cycle: the new frame loads and rx_valid stays 1. This is not an overrun.
- Counter widths: TX divider uses $clog2(BIT_CLKS) bits; RX divider uses $clog2(DIV) bits. Neither counter may wrap inside a bit.

## Test plan
Sim parameters: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, giving DIV=10 and BIT_CLKS=160.

- **8N1 loopback (tx tied to rx), send 0xA5**: tx shows 0,1,0,1,0,0,1,0,1,1, each level 160 clocks. rx_valid asserts with rx_data=0xA5 and all error flags 0. tx_ready is back high after 1600 clocks.
- **DATA_BITS=7, PARITY=2, send 0x53**: the parity bit on tx is 0. A bench-driven frame with 0x53 and parity bit 1 gives rx_data=0x53 and rx_parity_err=1.
- **Framing error**: drive 0x3C with the stop bit 0. Expect rx_data=0x3C, rx_frame_err=1, then a clean following frame with 0x3C and no errors.
- **Glitch rejection**: pull rx low for 30 clocks, then high. Expect no rx_valid and the RX FSM back in IDLE within 2 bit times.
- **Overrun**: hold rx_ready=0 and send 0x11 then 0x22. Expect rx_data=0x11 and rx_overrun=1. Pulse rx_ready; rx_valid and rx_overrun clear the next cycle.
- **Reset mid-transmit**: drop rst_n during data bit 3 of 0xFF. tx=1 immediately; after release tx_ready=1 and a fresh 0x5A transmits correctly.

Source files
------------

// File: rtl/uart_xcvr_if.sv
// Byte-stream side of the UART transceiver: TX and RX valid/ready channels
// plus the per-frame receive status flags.
interface uart_xcvr_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_xcvr.sv
// Parametrised full-duplex UART: valid/ready byte channels on the bus side,
// oversampled majority-vote receiver with parity/framing/overrun reporting.
module uart_xcvr #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_xcvr_if.slave bus,
  output logic       tx,
  input  logic       rx
);

  localparam int unsigned DIV      = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned BIT_CLKS = DIV * OVERSAMPLE;
  localparam int unsigned TxCntW   = $clog2(BIT_CLKS);
  localparam int unsigned DivW     = $clog2(DIV);
  localparam int unsigned TcntW    = $clog2(OVERSAMPLE + 1);

  localparam logic [TxCntW-1:0] TxCntMax = TxCntW'(BIT_CLKS - 1);
  localparam logic [DivW-1:0]   DivMax   = DivW'(DIV - 1);
  localparam logic [2:0]        LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0]        LastStop = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_xcvr: derived DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_xcvr: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_xcvr: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_xcvr: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- transmitter
  state_e                tx_state_q, tx_state_d;
  logic [TxCntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;
  logic                  tx_bit_end;

  assign tx_bit_end   = (tx_cnt_q == TxCntMax);
  assign bus.tx_ready = (tx_state_q == StIdle);
  assign tx           = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = 1'b1;
    if (tx_state_q != StIdle) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TxCntW'(1);
    end
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (bus.tx_valid) begin
          tx_state_d = StStart;
          tx_shift_d = bus.tx_data[DATA_BITS-1:0];
          tx_par_d   = (PARITY == 1) ? ~^bus.tx_data[DATA_BITS-1:0]
                                     : ^bus.tx_data[DATA_BITS-1:0];
        end
      end
      StStart: begin
        if (tx_bit_end) begin
          tx_state_d = StData;
          tx_bit_d   = '0;
        end
      end
      StData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastData) begin
            tx_state_d = (PARITY != 0) ? StParity : StStop;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tx_bit_end) begin
          tx_state_d = StStop;
          tx_bit_d   = '0;
        end
      end
      StStop: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LastStop) begin
            tx_state_d = StIdle;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
    // Line level is registered from the next state so tx changes on the same edge.
    case (tx_state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = tx_shift_d[0];
      StParity: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // ------------------------------------------------------------------- receiver
  logic                 rx_meta_q, rx_s_q;
  logic [DivW-1:0]      div_q;
  logic                 tick;
  state_e               rx_state_q, rx_state_d;
  logic [TcntW-1:0]     rx_tcnt_q, rx_tcnt_d, rx_tcnt_nxt;
  logic [1:0]           rx_smp_q, rx_smp_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_pe_q, rx_pe_d;
  logic                 rx_fe_q, rx_fe_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_maj, rx_centre, rx_accept, rx_exp_par;

  assign tick        = (div_q == DivMax);
  assign rx_tcnt_nxt = rx_tcnt_q + TcntW'(1);
  assign rx_centre   = tick && (rx_tcnt_nxt == TcntW'(OVERSAMPLE));
  assign rx_maj      = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s_q) |
                       (rx_smp_q[1] & rx_s_q);
  assign rx_accept   = rx_valid_q & bus.rx_ready;
  assign rx_exp_par  = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_pe_q;
  assign bus.rx_frame_err  = rx_fe_q;
  assign bus.rx_overrun    = rx_ovr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_smp_d   = rx_smp_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_data_d  = rx_data_q;
    rx_pe_d    = rx_pe_q;
    rx_fe_d    = rx_fe_q;
    rx_valid_d = rx_valid_q & ~rx_accept;
    rx_ovr_d   = rx_ovr_q & ~rx_accept;
    // Tick count runs so the third majority sample lands on OVERSAMPLE, then restarts.
    if (rx_state_q != StIdle && tick) begin
      rx_tcnt_d = rx_centre ? '0 : rx_tcnt_nxt;
      if (rx_tcnt_nxt == TcntW'(OVERSAMPLE - 2)) rx_smp_d[0] = rx_s_q;
      if (rx_tcnt_nxt == TcntW'(OVERSAMPLE - 1)) rx_smp_d[1] = rx_s_q;
    end
    case (rx_state_q)
      StIdle: begin
        if (tick && !rx_s_q) begin
          rx_state_d = StStart;
          rx_tcnt_d  = TcntW'(OVERSAMPLE / 2 - 1);
          rx_perr_d  = 1'b0;
        end
      end
      StStart: begin
        if (rx_centre) begin
          rx_state_d = rx_maj ? StIdle : StData;
          rx_bit_d   = '0;
        end
      end
      StData: begin
        if (rx_centre) begin
          rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LastData) begin
            rx_state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (rx_centre) begin
          rx_perr_d  = rx_maj ^ rx_exp_par;
          rx_state_d = StStop;
        end
      end
      StStop: begin
        if (rx_centre) begin
          rx_state_d = StIdle;
          if (!rx_valid_q || rx_accept) begin
            rx_valid_d = 1'b1;
            rx_data_d  = 8'(rx_shift_q);
            rx_pe_d    = (PARITY != 0) && rx_perr_q;
            rx_fe_d    = ~rx_maj;
          end else begin
            rx_ovr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      div_q      <= '0;
      rx_state_q <= StIdle;
      rx_tcnt_q  <= '0;
      rx_smp_q   <= 2'b11;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      div_q      <= tick ? '0 : div_q + DivW'(1);
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_smp_q   <= rx_smp_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: an 8N1 instance (loopback-capable) and a 7E2 instance,
// checked against a frame-level bit-list model with randomized bytes.
module tb_uart_xcvr;
  localparam int unsigned CF   = 1600000;
  localparam int unsigned BD   = 10000;
  localparam int unsigned OS   = 16;
  localparam int          BITC = 160;

  typedef logic bitq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_xcvr_if bus8();
  uart_xcvr_if bus7();
  logic tx8, tx7, rx8;
  logic drv8 = 1'b1;
  logic drv7 = 1'b1;
  logic loop8 = 1'b0;
  assign rx8 = loop8 ? tx8 : drv8;

  uart_xcvr #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
              .OVERSAMPLE(OS)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .tx(tx8), .rx(rx8)
  );

  uart_xcvr #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
              .OVERSAMPLE(OS)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7), .tx(tx7), .rx(drv7)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame as a list of line levels; par: 0 none, 1 odd, 2 even.
  function automatic bitq_t frame_bits(input logic [7:0] data, input int nbits, input int par,
                                       input int nstop, input bit bad_par, input bit bad_stop);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (par != 0) begin
      logic p;
      p = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      q.push_back(p ^ bad_par);
    end
    for (int i = 0; i < nstop; i++) q.push_back((i == 0) ? ~bad_stop : 1'b1);
    return q;
  endfunction

  function automatic logic get_tx(input int sel);
    return (sel == 7) ? tx7 : tx8;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 7) ? bus7.tx_ready : bus8.tx_ready;
  endfunction

  task automatic get_rx(input int sel, output logic v, output logic [7:0] d, output logic pe,
                        output logic fe, output logic ov);
    if (sel == 7) begin
      v = bus7.rx_valid; d = bus7.rx_data; pe = bus7.rx_parity_err;
      fe = bus7.rx_frame_err; ov = bus7.rx_overrun;
    end else begin
      v = bus8.rx_valid; d = bus8.rx_data; pe = bus8.rx_parity_err;
      fe = bus8.rx_frame_err; ov = bus8.rx_overrun;
    end
  endtask

  task automatic set_tx(input int sel, input logic [7:0] d, input logic v);
    if (sel == 7) begin bus7.tx_data = d; bus7.tx_valid = v; end
    else begin bus8.tx_data = d; bus8.tx_valid = v; end
  endtask

  // Send one byte and check every clock of the line against the model.
  task automatic send_tx(input int sel, input logic [7:0] data, input int nbits, input int par,
                         input int nstop, input bit keep);
    bitq_t bits;
    int bad;
    int guard = 0;
    bits = frame_bits(data, nbits, par, nstop, 1'b0, 1'b0);
    while (get_ready(sel) !== 1'b1 && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 5000) check($sformatf("tx%0d_ready_wait", sel), 0, 1);
    @(negedge clk);
    set_tx(sel, data, 1'b1);
    @(posedge clk); #1;
    if (!keep) set_tx(sel, data, 1'b0);
    for (int b = 0; b < bits.size(); b++) begin
      bad = 0;
      for (int c = 0; c < BITC; c++) begin
        if (get_tx(sel) !== bits[b]) bad++;
        if (get_ready(sel) !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      check($sformatf("tx%0d_d%02h_bit%0d_bad_cycles", sel, data, b), bad, 0);
    end
    check($sformatf("tx%0d_ready_after_frame", sel), get_ready(sel), 1);
    check($sformatf("tx%0d_idle_after_frame", sel), get_tx(sel), 1);
  endtask

  task automatic drive_rx(input int sel, input bitq_t bits);
    for (int b = 0; b < bits.size(); b++) begin
      @(negedge clk);
      if (sel == 7) drv7 = bits[b]; else drv8 = bits[b];
      repeat (BITC - 1) @(negedge clk);
    end
    @(negedge clk);
    if (sel == 7) drv7 = 1'b1; else drv8 = 1'b1;
    repeat (2 * BITC) @(negedge clk);
  endtask

  task automatic expect_rx(input int sel, input string tag, input logic [7:0] d,
                           input logic pe, input logic fe, input logic ov);
    logic v, gpe, gfe, gov;
    logic [7:0] gd;
    int guard = 0;
    get_rx(sel, v, gd, gpe, gfe, gov);
    while (v !== 1'b1 && guard < 4000) begin
      @(posedge clk); #1; guard++;
      get_rx(sel, v, gd, gpe, gfe, gov);
    end
    check({tag, "_valid"}, v, 1);
    check({tag, "_data"}, gd, d);
    check({tag, "_perr"}, gpe, pe);
    check({tag, "_ferr"}, gfe, fe);
    check({tag, "_ovr"}, gov, ov);
  endtask

  task automatic accept(input int sel, input string tag);
    logic v, gpe, gfe, gov;
    logic [7:0] gd;
    @(negedge clk);
    if (sel == 7) bus7.rx_ready = 1'b1; else bus8.rx_ready = 1'b1;
    @(posedge clk); #1;
    if (sel == 7) bus7.rx_ready = 1'b0; else bus8.rx_ready = 1'b0;
    get_rx(sel, v, gd, gpe, gfe, gov);
    check({tag, "_valid_clr"}, v, 0);
    check({tag, "_ovr_clr"}, gov, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, d2;
    bit bp, bs;
    int cnt;
    set_tx(8, 8'h00, 1'b0);
    set_tx(7, 8'h00, 1'b0);
    bus8.rx_ready = 1'b0;
    bus7.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx8", tx8, 1);
    check("rst_tx7", tx7, 1);
    check("rst_ready8", bus8.tx_ready, 1);
    check("rst_rxvalid8", bus8.rx_valid, 0);
    check("rst_rxdata8", bus8.rx_data, 0);
    check("rst_flags8", {bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_overrun}, 0);
    check("rst_rxvalid7", bus7.rx_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback, directed then random bytes.
    loop8 = 1'b1;
    send_tx(8, 8'hA5, 8, 0, 1, 1'b0);
    expect_rx(8, "lb_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    accept(8, "lb_a5");
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      send_tx(8, d, 8, 0, 1, 1'b0);
      expect_rx(8, $sformatf("lb_rand%0d", i), d, 1'b0, 1'b0, 1'b0);
      accept(8, $sformatf("lb_rand%0d", i));
    end

    // Back-to-back with tx_valid held: second frame overruns the unaccepted first.
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    send_tx(8, d, 8, 0, 1, 1'b1);
    send_tx(8, d2, 8, 0, 1, 1'b0);
    expect_rx(8, "b2b", d, 1'b0, 1'b0, 1'b1);
    accept(8, "b2b");
    loop8 = 1'b0;

    // 7E2 transmit and receive.
    send_tx(7, 8'h53, 7, 2, 2, 1'b0);
    d = 8'($urandom_range(0, 255));
    send_tx(7, d, 7, 2, 2, 1'b0);
    drive_rx(7, frame_bits(8'h53, 7, 2, 2, 1'b1, 1'b0));
    expect_rx(7, "e7_badpar", 8'h53, 1'b1, 1'b0, 1'b0);
    accept(7, "e7_badpar");
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      bp = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      drive_rx(7, frame_bits(d, 7, 2, 2, bp, bs));
      expect_rx(7, $sformatf("e7_rand%0d", i), d & 8'h7F, bp, bs, 1'b0);
      accept(7, $sformatf("e7_rand%0d", i));
    end

    // Framing error then clean frame.
    drive_rx(8, frame_bits(8'h3C, 8, 0, 1, 1'b0, 1'b1));
    expect_rx(8, "ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
    accept(8, "ferr");
    drive_rx(8, frame_bits(8'h3C, 8, 0, 1, 1'b0, 1'b0));
    expect_rx(8, "ferr_clean", 8'h3C, 1'b0, 1'b0, 1'b0);
    accept(8, "ferr_clean");

    // Glitch of 30 clocks must not start a frame.
    @(negedge clk);
    drv8 = 1'b0;
    repeat (30) @(negedge clk);
    drv8 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 2 * BITC; c++) begin
      @(posedge clk); #1;
      if (bus8.rx_valid) cnt++;
    end
    check("glitch_valid_cycles", cnt, 0);
    drive_rx(8, frame_bits(8'h96, 8, 0, 1, 1'b0, 1'b0));
    expect_rx(8, "post_glitch", 8'h96, 1'b0, 1'b0, 1'b0);
    accept(8, "post_glitch");

    // Overrun: second frame dropped while the first is held.
    drive_rx(8, frame_bits(8'h11, 8, 0, 1, 1'b0, 1'b0));
    drive_rx(8, frame_bits(8'h22, 8, 0, 1, 1'b0, 1'b0));
    expect_rx(8, "ovr", 8'h11, 1'b0, 1'b0, 1'b1);
    accept(8, "ovr");
    check("ovr_data_held", bus8.rx_data, 8'h11);

    // Reset during data bit 3 of 0xFF.
    @(negedge clk);
    set_tx(8, 8'hFF, 1'b1);
    @(posedge clk); #1;
    set_tx(8, 8'hFF, 1'b0);
    repeat (4 * BITC + 80) @(posedge clk);
    #1;
    check("pre_rst_ready_low", bus8.tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_high", tx8, 1);
    check("rst_mid_ready", bus8.tx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", bus8.tx_ready, 1);
    loop8 = 1'b1;
    send_tx(8, 8'h5A, 8, 0, 1, 1'b0);
    expect_rx(8, "post_rst_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
    accept(8, "post_rst_5a");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
